// File: rtl/gpio_debounce_pkg.sv
// Shared register offsets, debounce defaults and a byte-lane mask helper for gpio_debounce.
// Imported by the top level and by the per-pin debounce cell.
package gpio_debounce_pkg;

    localparam logic [5:0] ADDR_FILT  = 6'h00;
    localparam logic [5:0] ADDR_PRESC = 6'h04;
    localparam logic [5:0] ADDR_IER   = 6'h08;
    localparam logic [5:0] ADDR_ISR   = 6'h0C;

    localparam int DEB_LEN_DEFAULT = 4;
    // Wide enough for the largest legal DEB_LEN of 15.
    localparam int CNT_W = 4;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_debounce_if.sv
// Register bus for gpio_debounce: write strobe, byte enables, address, write data and
// combinational read data. No handshake; a write lands on the clock edge it is presented.
interface gpio_debounce_if;
    logic        write_i;
    logic [3:0]  data_be_i;
    logic [5:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport slave  (input  write_i, data_be_i, addr_i, wdata_i, output rdata_o);
    modport master (output write_i, data_be_i, addr_i, wdata_i, input  rdata_o);
endinterface

// File: rtl/gpio_deb_cell.sv
// One pin: two-flop synchronizer, tick-driven agreement counter and committed filt state.
// Commits DEB_LEN ticks after sync2 first disagrees; rise_o/fall_o pulse in the commit cycle.
module gpio_deb_cell
    import gpio_debounce_pkg::*;
#(
    parameter int DEB_LEN = DEB_LEN_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic pin_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q,  filt_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = pin_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        rise_o  = 1'b0;
        fall_o  = 1'b0;
        if (tick_i) begin
            if (sync2_q == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEB_LEN - 1)) begin
                filt_d = sync2_q;
                cnt_d  = '0;
                rise_o = sync2_q;
                fall_o = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input debouncer with prescaled sampling ticks, register map and edge interrupts.
// Interrupt logic (IER/ISR/irq_o) exists only with GPIO_DEBOUNCE_IRQ_EN defined.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEB_LEN = DEB_LEN_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gpio_debounce_if.slave    bus,
    input  logic [WIDTH-1:0]  pins_i,
    output logic [WIDTH-1:0]  pins_o,
    output logic              irq_o
);

    logic [15:0]      presc_q, presc_d;
    logic [15:0]      presc_cnt_q, presc_cnt_d;
    logic             tick;
    logic [WIDTH-1:0] rise_w, fall_w;
    logic [31:0]      lane_mask;
    logic [31:0]      rd_raw;

    assign lane_mask = be_mask(bus.data_be_i);
    // A PRESC write below the running count makes the very next cycle a tick.
    assign tick = (presc_cnt_q >= presc_q);

    always_comb begin
        presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
        presc_d     = presc_q;
        if (bus.write_i && bus.addr_i == ADDR_PRESC)
            presc_d = (presc_q & ~lane_mask[15:0]) | (bus.wdata_i[15:0] & lane_mask[15:0]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q     <= '0;
            presc_cnt_q <= '0;
        end else begin
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        gpio_deb_cell #(.DEB_LEN(DEB_LEN)) u_cell (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick),
            .pin_i  (pins_i[i]),
            .filt_o (pins_o[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [31:0] ier_q, ier_d;
    logic [31:0] isr_q, isr_d;
    logic [31:0] isr_clr;
    logic        irq_q, irq_d;

    always_comb begin
        ier_d   = ier_q;
        isr_clr = '0;
        if (bus.write_i && bus.addr_i == ADDR_IER)
            ier_d = (ier_q & ~lane_mask) | (bus.wdata_i & lane_mask);
        if (bus.write_i && bus.addr_i == ADDR_ISR)
            isr_clr = bus.wdata_i & lane_mask;
        // New edges win over a simultaneous W1C so no event is lost.
        isr_d = (isr_q & ~isr_clr) | {16'(fall_w), 16'(rise_w)};
        irq_d = |(isr_q & ier_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ier_q <= '0;
            isr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq;
    assign unused_irq = ^{rise_w, fall_w, bus.wdata_i[31:16]};
    assign irq_o      = 1'b0;
`endif

    always_comb begin
        rd_raw = '0;
        case (bus.addr_i)
            ADDR_FILT:  rd_raw = 32'(pins_o);
            ADDR_PRESC: rd_raw = {16'h0000, presc_q};
`ifdef GPIO_DEBOUNCE_IRQ_EN
            ADDR_IER:   rd_raw = ier_q;
            ADDR_ISR:   rd_raw = isr_q;
`endif
            default:    rd_raw = '0;
        endcase
    end

    assign bus.rdata_o = rd_raw & lane_mask;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: debounce timing, glitch rejection, prescaler, register
// access, interrupt pending/enable behaviour and reset abandonment.
module tb_gpio_debounce;
    import gpio_debounce_pkg::*;

`ifdef GPIO_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pins_i;
    logic [15:0] pins_o;
    logic        irq_o;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd;

    gpio_debounce_if bus_if ();

    gpio_debounce #(.WIDTH(16), .DEB_LEN(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus_if),
        .pins_i (pins_i),
        .pins_o (pins_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    // Interrupt registers read back as zero when the feature is compiled out.
    function automatic logic [31:0] irqv(input logic [31:0] v);
        return IRQ_EN ? v : 32'h0;
    endfunction

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.write_i   = 1'b1;
        bus_if.addr_i    = a;
        bus_if.wdata_i   = d;
        bus_if.data_be_i = be;
        step(1);
        bus_if.write_i   = 1'b0;
        bus_if.wdata_i   = '0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [3:0] be, output logic [31:0] d);
        bus_if.write_i   = 1'b0;
        bus_if.addr_i    = a;
        bus_if.data_be_i = be;
        #1;
        d = bus_if.rdata_o;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        tests++; if (pins_o !== 16'h0) begin fails++; $display("FAIL reset_pins got=%h exp=%h", pins_o, 16'h0); end
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
        rst = 1'b0;
        step(1);
        bus_read(ADDR_PRESC, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_presc got=%h exp=%h", rd, 32'h0); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_isr got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_regs;
        bus_write(ADDR_PRESC, 32'h1234_ABCD, 4'b0001);
        bus_read(ADDR_PRESC, 4'hF, rd);
        tests++; if (rd !== 32'h0000_00CD) begin fails++; $display("FAIL presc_be got=%h exp=%h", rd, 32'h0000_00CD); end
        bus_write(ADDR_PRESC, 32'h0000_5A5A, 4'hF);
        bus_read(ADDR_PRESC, 4'b0010, rd);
        tests++; if (rd !== 32'h0000_5A00) begin fails++; $display("FAIL presc_lane got=%h exp=%h", rd, 32'h0000_5A00); end
        bus_write(ADDR_PRESC, 32'h0, 4'hF);
        bus_write(ADDR_FILT, 32'hFFFF_FFFF, 4'hF);
        bus_read(ADDR_FILT, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL filt_ro got=%h exp=%h", rd, 32'h0); end
        bus_write(6'h10, 32'hFFFF_FFFF, 4'hF);
        bus_read(6'h10, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL unmapped got=%h exp=%h", rd, 32'h0); end
        bus_write(ADDR_IER, 32'hFFFF_FFFF, 4'b1000);
        bus_read(ADDR_IER, 4'hF, rd);
        tests++; if (rd !== irqv(32'hFF00_0000)) begin fails++; $display("FAIL ier_be got=%h exp=%h", rd, irqv(32'hFF00_0000)); end
        bus_write(ADDR_IER, 32'h0, 4'hF);
    endtask

    task automatic test_rise;
        pins_i[0] = 1'b1;
        step(5);
        tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL rise_edge5 got=%h exp=%h", pins_o, 16'h0000); end
        step(1);
        tests++; if (pins_o !== 16'h0001) begin fails++; $display("FAIL rise_edge6 got=%h exp=%h", pins_o, 16'h0001); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== irqv(32'h0000_0001)) begin fails++; $display("FAIL rise_isr got=%h exp=%h", rd, irqv(32'h1)); end
        step(2);
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL rise_irq_masked got=%b exp=0", irq_o); end
        pins_i[0] = 1'b0;
        step(8);
        tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL fall_pin0 got=%h exp=%h", pins_o, 16'h0000); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== irqv(32'h0001_0001)) begin fails++; $display("FAIL fall_isr got=%h exp=%h", rd, irqv(32'h0001_0001)); end
        bus_write(ADDR_ISR, 32'hFFFF_FFFF, 4'hF);
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL isr_w1c got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_glitch;
        pins_i[3] = 1'b1;
        step(3);
        pins_i[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL glitch_pins cyc=%0d got=%h exp=%h", k, pins_o, 16'h0000); end
        end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL glitch_isr got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_presc;
        int cyc;
        bus_write(ADDR_PRESC, 32'd9, 4'hF);
        pins_i[5] = 1'b1;
        cyc = 0;
        while (pins_o[5] !== 1'b1 && cyc < 100) begin
            step(1);
            cyc++;
        end
        tests++; if (cyc < 32 || cyc > 52) begin fails++; $display("FAIL presc_delay got=%0d exp=32..52", cyc); end
        pins_i[5] = 1'b0;
        cyc = 0;
        while (pins_o[5] !== 1'b0 && cyc < 100) begin
            step(1);
            cyc++;
        end
        tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL presc_fall got=%h exp=%h", pins_o, 16'h0000); end
        bus_write(ADDR_PRESC, 32'd0, 4'hF);
        bus_write(ADDR_ISR, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_fall_irq;
        bus_write(ADDR_IER, 32'h0002_0000, 4'hF);
        pins_i[1] = 1'b1;
        step(8);
        bus_write(ADDR_ISR, 32'hFFFF_FFFF, 4'hF);
        step(1);
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_rise_masked got=%b exp=0", irq_o); end
        pins_i[1] = 1'b0;
        step(6);
        tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL pin1_fall got=%h exp=%h", pins_o, 16'h0000); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== irqv(32'h0002_0000)) begin fails++; $display("FAIL isr17 got=%h exp=%h", rd, irqv(32'h0002_0000)); end
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_same_cycle got=%b exp=0", irq_o); end
        step(1);
        tests++; if (irq_o !== IRQ_EN) begin fails++; $display("FAIL irq_next_cycle got=%b exp=%b", irq_o, IRQ_EN); end
        bus_write(ADDR_ISR, 32'h0002_0000, 4'hF);
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL isr17_clear got=%h exp=%h", rd, 32'h0); end
        step(1);
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b exp=0", irq_o); end
        bus_write(ADDR_IER, 32'h0, 4'hF);
    endtask

    task automatic test_w1c_collision;
        pins_i[0] = 1'b1;
        step(5);
        bus_write(ADDR_ISR, 32'h0000_0001, 4'hF);
        tests++; if (pins_o !== 16'h0001) begin fails++; $display("FAIL coll_pin0 got=%h exp=%h", pins_o, 16'h0001); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== irqv(32'h0000_0001)) begin fails++; $display("FAIL coll_isr got=%h exp=%h", rd, irqv(32'h1)); end
        bus_write(ADDR_ISR, 32'h0000_0001, 4'hF);
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL coll_clear got=%h exp=%h", rd, 32'h0); end
        pins_i[0] = 1'b0;
        step(8);
        bus_write(ADDR_ISR, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_reset_mid;
        bus_write(ADDR_IER, 32'h0000_0080, 4'hF);
        pins_i[7] = 1'b1;
        step(3);
        rst = 1'b1;
        step(2);
        tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL rst_mid_pins got=%h exp=%h", pins_o, 16'h0000); end
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL rst_mid_irq got=%b exp=0", irq_o); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_mid_isr got=%h exp=%h", rd, 32'h0); end
        bus_read(ADDR_IER, 4'hF, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_mid_ier got=%h exp=%h", rd, 32'h0); end
        rst = 1'b0;
        step(5);
        tests++; if (pins_o !== 16'h0000) begin fails++; $display("FAIL rst_rel_edge5 got=%h exp=%h", pins_o, 16'h0000); end
        step(1);
        tests++; if (pins_o !== 16'h0080) begin fails++; $display("FAIL rst_rel_edge6 got=%h exp=%h", pins_o, 16'h0080); end
        bus_read(ADDR_ISR, 4'hF, rd);
        tests++; if (rd !== irqv(32'h0000_0080)) begin fails++; $display("FAIL rst_rel_isr got=%h exp=%h", rd, irqv(32'h80)); end
    endtask

    initial begin
        rst              = 1'b1;
        pins_i           = '0;
        bus_if.write_i   = 1'b0;
        bus_if.data_be_i = 4'hF;
        bus_if.addr_i    = '0;
        bus_if.wdata_i   = '0;
        test_reset;
        test_regs;
        test_rise;
        test_glitch;
        test_presc;
        test_fall_irq;
        test_w1c_collision;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
